uart_tx_buf: RTL and testbench
==============================

Name: uart_tx_buf

Overview:
- Buffered UART transmitter, the send-side counterpart to the team's uart_rx; drives a serial line that a uart_rx in another instance (or a host) samples.
- Byte-wide push interface into a small FIFO. A baud divider and frame FSM serialize 8N1 frames (start bit, 8 data bits LSB first, stop bit).
- Transmits queued bytes back-to-back with no idle gap, so a host can stream without per-byte handshaking.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per serial bit; must be >= 1 (1 matches the team's existing one-bit-per-clock blocks).
- FIFO_DEPTH, 4, byte slots in the FIFO; must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- din  in  8  byte to queue; sampled only on an accepted write.
- wr_en  in  1  write request.
- wr_rdy  out  1  FIFO not full; a write is accepted on an edge where wr_en && wr_rdy.
- tx  out  1  serial line; idle high; registered output.
- busy  out  1  high while a frame is on the line (START..STOP).
- count  out  $clog2(FIFO_DEPTH+1)  bytes queued, excluding the byte being shifted.

Behaviour:
- Reset: rst high at an edge gives tx=1, busy=0, wr_rdy=1, count=0. The FIFO is flushed, the FSM goes to IDLE and the baud counter clears. rst mid-frame aborts the frame; tx is 1 from that edge, with no partial stop bit.
- FIFO:
  - Push on wr_en && wr_rdy.
  - wr_rdy = (count != FIFO_DEPTH), derived from registered count.
  - A write while full is ignored with no side effects, even if the FSM pops on the same edge.
  - Push and pop on the same edge leave count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If count != 0 at an edge: pop the head into the shift register, enter START, tx=0, busy=1.
  - Latency: a write accepted at edge E0 into an idle, empty block drives tx low from edge E1.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles per bit, LSB first.
  - Shift right after each bit; a 3-bit bit index counts 0..7.
  - After bit 7 completes, enter STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end:
  - if count != 0: pop and enter START on the same edge (no idle cycle, busy stays 1);
  - else: IDLE, busy=0.
- Frame length: exactly 10*CLKS_PER_BIT cycles (11* with the parity option below).
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state entry. CLKS_PER_BIT=1 degenerates to one bit per clock.
- din changes after acceptance have no effect on queued or in-flight bytes.
- busy is never 1 while tx is idle-high in IDLE. tx never glitches (registered).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state between DATA and STOP drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11 bits.
- Undefined: no PARITY state. 8N1 framing, 10 bits per frame.

Test Plan:
- Reset/idle: assert rst 2 cycles, release, run 20 cycles -> tx=1, busy=0, wr_rdy=1, count=0 throughout.
- Single byte 8'h55 written at edge E0 (CLKS_PER_BIT=4):
  - tx=0 on cycles E1..E4;
  - data bits 1,0,1,0,1,0,1,0 for 4 cycles each;
  - tx=1 stop for 4 cycles;
  - busy drops at E41.
- Back-to-back: write 8'hA5, 8'h3C on consecutive cycles -> two frames decoded as A5 then 3C, with the second start bit immediately following the first stop bit (no idle cycle). Count goes 1 then 0.
- Full FIFO (DEPTH=4): write 6 bytes 1..6 on consecutive cycles.
  - First pops immediately; bytes 2..5 fill the FIFO; wr_rdy=0; byte 6 is dropped.
  - Line carries 1,2,3,4,5 only.
- Reset mid-frame: rst during DATA bit 3 of 8'hFF with 2 bytes queued -> tx=1 next edge, count=0, busy=0, no further frames.
- UART_TX_PARITY_EN defined: send 8'h07 (three ones) -> parity bit 1. Send 8'h03 -> parity bit 0. Frame = 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_tx_buf.sv
// -----------------------------------------------------------------------------
// uart_tx_buf
//   Buffered UART transmitter. Bytes are pushed into a small FIFO and sent as
//   8N1 frames (start, 8 data bits LSB first, stop). Queued bytes go out
//   back-to-back: the next start bit directly follows the previous stop bit.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 1)
//   FIFO_DEPTH    byte slots in the FIFO (power of 2, >= 2)
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   din     in   [7:0] byte to queue, sampled on an accepted write
//   wr_en   in   write request
//   wr_rdy  out  FIFO not full; a write is accepted when wr_en && wr_rdy
//   tx      out  serial line, idle high, registered
//   busy    out  high while a frame is on the line
//   count   out  bytes queued, excluding the byte being shifted
//
// Optional build macro
//   UART_TX_PARITY_EN  adds an even-parity bit between the data bits and the
//                      stop bit (11-bit frames).
// -----------------------------------------------------------------------------
module uart_tx_buf #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        din,
  input  logic                              wr_en,
  output logic                              wr_rdy,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // FIFO storage and pointers
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  // Frame FSM state
  state_t            state_q, state_n;
  logic [BAUD_W-1:0] baud_q, baud_n;
  logic [2:0]        bit_q, bit_n;
  logic [7:0]        shift_q, shift_n;
  logic              tx_q, tx_n;
  logic              baud_last;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_n;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  assign wr_rdy    = (cnt_q != CNT_FULL);
  assign push      = wr_en && wr_rdy;
  assign head      = mem[rd_ptr];
  assign baud_last = (baud_q == BAUD_LAST);

  assign tx    = tx_q;
  assign busy  = (state_q != IDLE);
  assign count = cnt_q;

  // ---- FIFO write port (data only, never reset) ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // ---- FIFO control ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---- Frame FSM: next state, next line level, pop request ----
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q + 1'b1;
    bit_n   = bit_q;
    shift_n = shift_q;
    tx_n    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif

    case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          shift_n = head;
`ifdef UART_TX_PARITY_EN
          par_n   = even_parity(head);
`endif
          state_n = START;
          tx_n    = 1'b0;
        end
      end

      START: begin
        tx_n = 1'b0;
        if (baud_last) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = 3'd0;
          tx_n    = shift_q[0];
        end
      end

      DATA: begin
        tx_n = shift_q[0];
        if (baud_last) begin
          baud_n  = '0;
          shift_n = shift_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n = bit_q + 3'd1;
            // Next level is the bit that lands in shift[0] after this shift.
            tx_n  = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_n = par_q;
        if (baud_last) begin
          state_n = STOP;
          baud_n  = '0;
          tx_n    = 1'b1;
        end
      end
`endif

      STOP: begin
        tx_n = 1'b1;
        if (baud_last) begin
          baud_n = '0;
          if (cnt_q != '0) begin
            // Chain straight into the next frame with no idle cycle.
            pop     = 1'b1;
            shift_n = head;
`ifdef UART_TX_PARITY_EN
            par_n   = even_parity(head);
`endif
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end

      default: begin
        state_n = IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

  // ---- Frame FSM control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      tx_q    <= tx_n;
    end
  end

  // ---- Shift datapath (never reset) ----
  always_ff @(posedge clk) begin
    shift_q <= shift_n;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_n;
`endif
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buf
//   Directed bench for uart_tx_buf at CLKS_PER_BIT=4, FIFO_DEPTH=4.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Define UART_TX_PARITY_EN for both bench and RTL to exercise parity frames.
// -----------------------------------------------------------------------------
module tb_uart_tx_buf;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       wr_en;
  logic       wr_rdy;
  logic       tx;
  logic       busy;
  logic [$clog2(DEPTH+1)-1:0] count;

  int n_checks;
  int n_err;

  uart_tx_buf #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .wr_en  (wr_en),
    .wr_rdy (wr_rdy),
    .tx     (tx),
    .busy   (busy),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"},     32'(tx),     32'd1);
    check({tag, " busy"},   32'(busy),   32'd0);
    check({tag, " wr_rdy"}, 32'(wr_rdy), 32'd1);
    check({tag, " count"},  32'(count),  32'd0);
  endtask

  // Checks tx/busy for one frame of byte b with parity bit p (ignored in the
  // 8N1 build). Called positioned at the falling edge after frame cycle
  // 'first'; returns at the falling edge after the last frame cycle.
  task automatic expect_frame(input string tag, input logic [7:0] b, input logic p,
                              input int first);
    logic [10:0] seq;
    seq = '0;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    seq[9]  = p;
    seq[10] = 1'b1;
`else
    seq[9]  = 1'b1;
    seq[10] = p;
`endif
    for (int c = first; c < FRAME_CYC; c++) begin
      if (c != first) @(negedge clk);
      check($sformatf("%s tx c%0d", tag, c),   32'(tx),   32'(seq[c / CPB]));
      check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
    end
  endtask

  initial begin
    logic [5:1] par_tab;
    logic [5:0] cnt_tab [6];
    logic       rdy_tab [6];

    n_checks = 0;
    n_err    = 0;
    rst   = 1'b1;
    wr_en = 1'b0;
    din   = 8'h00;

    // ---- reset and idle ----
    repeat (2) @(negedge clk);
    check_idle("rst");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle("idle");
    end

    // ---- single byte 0x55 ----
    din = 8'h55; wr_en = 1'b1;
    @(negedge clk);                     // after E0
    wr_en = 1'b0; din = 8'hAA;          // later din changes must not matter
    check("s55 tx E0",    32'(tx),    32'd1);
    check("s55 busy E0",  32'(busy),  32'd0);
    check("s55 count E0", 32'(count), 32'd1);
    @(negedge clk);                     // after E1
    check("s55 count E1", 32'(count), 32'd0);
    expect_frame("s55", 8'h55, 1'b0, 0);
    @(negedge clk);                     // after E41 (E45 with parity)
    check_idle("s55 end");

    // ---- back-to-back 0xA5, 0x3C ----
    din = 8'hA5; wr_en = 1'b1;
    @(negedge clk);                     // after E0
    check("b2b count E0", 32'(count), 32'd1);
    din = 8'h3C;
    @(negedge clk);                     // after E1: pop A5, push 3C
    wr_en = 1'b0; din = 8'h00;
    check("b2b count E1", 32'(count), 32'd1);
    expect_frame("bA5", 8'hA5, 1'b0, 0);
    @(negedge clk);                     // next start bit directly follows
    check("b2b count 2nd", 32'(count), 32'd0);
    expect_frame("b3C", 8'h3C, 1'b0, 0);
    @(negedge clk);
    check_idle("b2b end");

    // ---- fill the FIFO: bytes 1..6, byte 6 dropped ----
    cnt_tab = '{6'd1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd4};
    rdy_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 1; k <= 6; k++) begin
      din = 8'(k); wr_en = 1'b1;
      @(negedge clk);                   // after E(k-1)
      check($sformatf("full count w%0d", k),  32'(count),  32'(cnt_tab[k-1]));
      check($sformatf("full wr_rdy w%0d", k), 32'(wr_rdy), 32'(rdy_tab[k-1]));
    end
    wr_en = 1'b0; din = 8'h00;
    par_tab = 5'b01011;                 // even parity of bytes 5..1
    expect_frame("full b1", 8'h01, par_tab[1], 4);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("full count f%0d", k), 32'(count), 32'(5 - k));
      expect_frame($sformatf("full b%0d", k), 8'(k), par_tab[k], 0);
    end
    @(negedge clk);
    check_idle("full end");
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk);
      check("full no b6 tx",   32'(tx),   32'd1);
      check("full no b6 busy", 32'(busy), 32'd0);
    end

`ifdef UART_TX_PARITY_EN
    // ---- parity frames: 0x07 -> 1, 0x03 -> 0 ----
    din = 8'h07; wr_en = 1'b1;
    @(negedge clk);
    din = 8'h03;
    @(negedge clk);
    wr_en = 1'b0;
    expect_frame("p07", 8'h07, 1'b1, 0);
    @(negedge clk);
    expect_frame("p03", 8'h03, 1'b0, 0);
    @(negedge clk);
    check_idle("par end");
`endif

    // ---- reset during DATA bit 3 of 0xFF with 2 bytes queued ----
    din = 8'hFF; wr_en = 1'b1;
    @(negedge clk);                     // after E0
    din = 8'h11;
    @(negedge clk);                     // after E1: frame cycle 0
    din = 8'h22;
    @(negedge clk);                     // after E2: frame cycle 1
    wr_en = 1'b0;
    check("rmf count", 32'(count), 32'd2);
    repeat (16) @(negedge clk);         // after E18: frame cycle 17, bit 3
    check("rmf busy pre", 32'(busy), 32'd1);
    check("rmf tx pre",   32'(tx),   32'd1);
    rst = 1'b1;
    @(negedge clk);                     // after E19
    rst = 1'b0;
    check_idle("rmf rst");
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      @(negedge clk);
      check("rmf quiet tx",    32'(tx),    32'd1);
      check("rmf quiet busy",  32'(busy),  32'd0);
      check("rmf quiet count", 32'(count), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
